// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for DIGITS common-anode seven-segment digits that
// share one active-low cathode bus. A free-running divider sets the per-digit
// slot length. The first GUARD cycles of every slot keep all anodes off so the
// cathodes can settle without ghosting. New values are staged in pending
// registers and only take effect at a frame boundary, so a displayed frame
// never mixes old and new data.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD      = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic [DIGITS-1:0]   blank_mask,
    output logic [7:0]          c_out,
    output logic [DIGITS-1:0]   a_out,
    output logic                frame_done
);

    localparam int DIV_RAW = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Active-low hex decode, segment order {a,b,c,d,e,f,g,dp}, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h03;
            4'h1:    seg = 8'h9F;
            4'h2:    seg = 8'h25;
            4'h3:    seg = 8'h0D;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h49;
            4'h6:    seg = 8'h41;
            4'h7:    seg = 8'h1F;
            4'h8:    seg = 8'h01;
            4'h9:    seg = 8'h19;
            4'hA:    seg = 8'h11;
            4'hB:    seg = 8'hC1;
            4'hC:    seg = 8'h63;
            4'hD:    seg = 8'h85;
            4'hE:    seg = 8'h61;
            4'hF:    seg = 8'h71;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Scan position
    logic [CW-1:0]       div_cnt_r;
    logic [IW-1:0]       idx_r;

    // Staged (pending) and displayed (shadow) frame data
    logic [4*DIGITS-1:0] value_pd_r;
    logic [DIGITS-1:0]   dp_pd_r;
    logic [DIGITS-1:0]   blank_pd_r;
    logic                pend_r;
    logic [4*DIGITS-1:0] value_sh_r;
    logic [DIGITS-1:0]   dp_sh_r;
    logic [DIGITS-1:0]   blank_sh_r;

    // Output stage
    logic                wrap_d_r;
    logic                frame_done_r;
    logic [DIGITS-1:0]   a_out_r;
    logic [7:0]          c_out_r;

    // Combinational helpers
    logic                tick_s;
    logic                wrap_s;
    logic                seen_s;
    logic [DIGITS-1:0]   dark_s;
    logic [3:0]          nib_s;
    logic [7:0]          seg_s;
    logic [7:0]          cath_s;
    logic [DIGITS-1:0]   anode_s;

    assign tick_s = enable & (div_cnt_r == DIV_LAST);
    assign wrap_s = tick_s & (idx_r == IDX_LAST);

    // Slot divider and digit index; both freeze while the scan is disabled.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
            idx_r     <= '0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            idx_r     <= wrap_s ? '0 : idx_r + 1'b1;
        end else if (enable) begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end else begin
            div_cnt_r <= div_cnt_r;
            idx_r     <= idx_r;
        end
    end

    // Frame-synchronous load: stage on load, publish to shadow on the wrap tick.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            value_pd_r <= '0;
            dp_pd_r    <= '0;
            blank_pd_r <= '0;
            pend_r     <= 1'b0;
            value_sh_r <= '0;
            dp_sh_r    <= '0;
            blank_sh_r <= '0;
        end else if (wrap_s && load) begin
            // A load landing on the boundary bypasses staging entirely.
            value_sh_r <= value;
            dp_sh_r    <= dp_mask;
            blank_sh_r <= blank_mask;
            pend_r     <= 1'b0;
        end else if (wrap_s && pend_r) begin
            value_sh_r <= value_pd_r;
            dp_sh_r    <= dp_pd_r;
            blank_sh_r <= blank_pd_r;
            pend_r     <= 1'b0;
        end else if (load) begin
            value_pd_r <= value;
            dp_pd_r    <= dp_mask;
            blank_pd_r <= blank_mask;
            pend_r     <= 1'b1;
        end else begin
            pend_r     <= pend_r;
        end
    end

    // Leading-zero scan from the most significant digit downward.
    always_comb begin
        seen_s = 1'b0;
        dark_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((value_sh_r[4*i +: 4] != 4'h0) || dp_sh_r[i] || (i == 0)) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            dark_s[i] = blank_sh_r[i] | ((LZ_BLANK != 0) & ~seen_s);
        end
    end

    // Cathode and anode patterns for the current scan position.
    always_comb begin
        nib_s   = value_sh_r[{idx_r, 2'b00} +: 4];
        seg_s   = hex_to_seg(nib_s) & {7'h7F, ~dp_sh_r[idx_r]};
        cath_s  = 8'hFF;
        anode_s = '1;
        if (!enable || dark_s[idx_r]) begin
            cath_s = 8'hFF;
        end else begin
            cath_s = seg_s;
        end
        if (enable && (div_cnt_r >= GUARD_CNT)) begin
            for (int i = 0; i < DIGITS; i++) begin
                anode_s[i] = (idx_r != IW'(i));
            end
        end else begin
            anode_s = '1;
        end
    end

    // Registered pins; frame_done is delayed one extra stage to line up with
    // the first output cycle of digit 0.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wrap_d_r     <= 1'b0;
            frame_done_r <= 1'b0;
            a_out_r      <= '1;
            c_out_r      <= 8'hFF;
        end else begin
            wrap_d_r     <= wrap_s;
            frame_done_r <= wrap_d_r;
            a_out_r      <= anode_s;
            c_out_r      <= cath_s;
        end
    end

    assign a_out      = a_out_r;
    assign c_out      = c_out_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: the stimulus process issues loads and
// queues the digit images each frame must show; a monitor pops one entry each
// time an anode lights and compares anode and cathode patterns.
module tb_seg7_scan_driver;

    localparam int DIGITS     = 4;
    localparam int CLK_HZ     = 4000;
    localparam int REFRESH_HZ = 100;
    localparam int GUARD      = 2;
    localparam int LZ_BLANK   = 1;
    localparam int DIV        = 10;
    localparam int FRAME      = DIGITS * DIV;
    localparam int LIT_LEN    = DIV - GUARD;
    localparam int NFR        = 12;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [7:0]  c_out;
    logic [3:0]  a_out;
    logic        frame_done;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_on   = 1'b0;
    bit          chk_len  = 1'b0;

    logic [15:0] cur_val;
    logic [3:0]  cur_dp;
    logic [3:0]  cur_blank;

    logic [7:0]  lut [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg7_scan_driver #(
        .DIGITS     (DIGITS),
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .GUARD      (GUARD),
        .LZ_BLANK   (LZ_BLANK)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .c_out      (c_out),
        .a_out      (a_out),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: what digit d shows for a given value/dp/blank set.
    function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp,
                                             input logic [3:0] bl, input int d);
        int         top;
        logic [7:0] s;
        top = 0;
        for (int j = 0; j < DIGITS; j++) begin
            if ((v[4*j +: 4] != 4'h0) || dp[j]) top = j;
        end
        if (bl[d] || ((LZ_BLANK != 0) && (d > top))) return 8'hFF;
        s = lut[v[4*d +: 4]];
        if (dp[d]) s = s & 8'hFE;
        return s;
    endfunction

    task automatic push_frame(input bit extra2);
        exp_t e;
        for (int d = 0; d < DIGITS; d++) begin
            e.an  = 4'hF ^ (4'b0001 << d);
            e.seg = model_seg(cur_val, cur_dp, cur_blank, d);
            exp_q.push_back(e);
            if (extra2 && (d == 2)) exp_q.push_back(e);
        end
    endtask

    task automatic drive_idle();
        load       = 1'b0;
        value      = 16'($urandom);
        dp_mask    = 4'($urandom);
        blank_mask = 4'($urandom);
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        load       = 1'b1;
        value      = v;
        dp_mask    = dp;
        blank_mask = bl;
        cur_val    = v;
        cur_dp     = dp;
        cur_blank  = bl;
    endtask

    task automatic drive_rand_load();
        logic [15:0] v;
        v = 16'($urandom) >> (4 * $urandom_range(0, 3));
        drive_load(v, 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        do begin
            @(negedge clk_in);
            k++;
        end while ((frame_done !== 1'b1) && (k < 3 * FRAME));
        if (frame_done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL fd_timeout: frame_done absent for %0d cycles", 3 * FRAME);
        end
    endtask

    // Monitor: one look per cycle, 1 time unit after the rising edge.
    initial begin : monitor
        bit         prev_lit;
        bit         prev_fd;
        bit         fd_valid;
        bit         lit;
        bit         stable;
        int         len;
        int         en_cnt;
        logic [7:0] win_c;
        exp_t       e;
        prev_lit = 1'b0;
        prev_fd  = 1'b0;
        fd_valid = 1'b0;
        stable   = 1'b1;
        len      = 0;
        en_cnt   = 0;
        win_c    = 8'hFF;
        forever begin
            @(posedge clk_in);
            #1;
            if (reset !== 1'b1) begin
                prev_lit = 1'b0;
                prev_fd  = 1'b0;
                fd_valid = 1'b0;
                en_cnt   = 0;
                len      = 0;
            end else begin
                if (enable) en_cnt++;
                if (frame_done === 1'b1) begin
                    check("fd_width", 32'(prev_fd), 32'd0);
                    if (fd_valid) check("fd_period", 32'(en_cnt), 32'(FRAME));
                    fd_valid = 1'b1;
                    en_cnt   = 0;
                end
                prev_fd = (frame_done === 1'b1);
                lit = (a_out !== 4'hF);
                if (lit && !prev_lit) begin
                    len    = 1;
                    win_c  = c_out;
                    stable = 1'b1;
                    if (mon_on) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL scoreboard_empty: a_out=%b c_out=%h lit unexpectedly", a_out, c_out);
                        end else begin
                            e = exp_q.pop_front();
                            check("anode", 32'(a_out), 32'(e.an));
                            check("cathode", 32'(c_out), 32'(e.seg));
                        end
                    end
                end else if (lit) begin
                    len++;
                    if (c_out !== win_c) stable = 1'b0;
                end else if (prev_lit) begin
                    check("c_stable", 32'(stable), 32'd1);
                    if (chk_len) check("lit_len", 32'(len), 32'(LIT_LEN));
                end
                prev_lit = lit;
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        int p1;
        int p2;
        int k;
        reset   = 1'b0;
        enable  = 1'b0;
        drive_idle();
        cur_val = 16'h0; cur_dp = 4'h0; cur_blank = 4'h0;
        repeat (3) @(negedge clk_in);
        check("rst_a_out", 32'(a_out), 32'hF);
        check("rst_c_out", 32'(c_out), 32'hFF);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // First frame shows the zero shadow; 16'h1234 follows in the next.
        push_frame(1'b0);
        drive_load(16'h1234, 4'h0, 4'h0);
        push_frame(1'b0);
        mon_on  = 1'b1;
        chk_len = 1'b1;
        reset   = 1'b1;
        enable  = 1'b1;
        @(negedge clk_in);
        drive_idle();

        for (int it = 0; it < NFR; it++) begin
            wait_fd();
            p1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, FRAME - 1);
            p2 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, FRAME - 1) : 0;
            for (int j = 1; j < FRAME; j++) begin
                drive_idle();
                case (it)
                    0: if (j == 3) drive_load(16'h0050, 4'h0, 4'h0);
                    1: if (j == 3) drive_load(16'h0050, 4'b0100, 4'h0);
                    2: begin
                        if (j == 5) drive_load(16'hAAAA, 4'h0, 4'h0);
                        if (j == 7) drive_load(16'hFFFF, 4'h0, 4'h0);
                    end
                    3: if (j == FRAME - 1) drive_rand_load();
                    NFR - 1: begin
                        if (j == 22) chk_len = 1'b0;
                        if (j == 25) enable = 1'b0;
                        if (j == 26) begin
                            check("en_low_a_out", 32'(a_out), 32'hF);
                            check("en_low_c_out", 32'(c_out), 32'hFF);
                        end
                        if (j == 27) drive_rand_load();
                        if (j == 29) enable = 1'b1;
                        if (j == 36) chk_len = 1'b1;
                    end
                    default: if ((j == p1) || (j == p2)) drive_rand_load();
                endcase
                @(negedge clk_in);
            end
            drive_idle();
            push_frame(it == NFR - 2);
        end

        // Asynchronous reset while a digit is lit, with a load still pending.
        wait_fd();
        k = 0;
        while ((a_out === 4'hF) && (k < DIV)) begin
            @(negedge clk_in);
            k++;
        end
        drive_load(16'h9876, 4'h0, 4'h0);
        @(negedge clk_in);
        drive_idle();
        @(negedge clk_in);
        mon_on  = 1'b0;
        chk_len = 1'b0;
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        check("arst_a_out", 32'(a_out), 32'hF);
        check("arst_c_out", 32'(c_out), 32'hFF);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(negedge clk_in);
        check("arst_hold_a_out", 32'(a_out), 32'hF);

        // Shadow and pending were cleared: two frames of the zero image.
        cur_val = 16'h0; cur_dp = 4'h0; cur_blank = 4'h0;
        push_frame(1'b0);
        push_frame(1'b0);
        mon_on  = 1'b1;
        chk_len = 1'b1;
        reset   = 1'b1;
        wait_fd();
        wait_fd();
        mon_on = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver that scans `DIGITS` common-anode digits from one shared cathode bus. It generalises the single-digit encoder with configurable digit count, scan rate, decimal-point and blanking masks, leading-zero suppression, anti-ghosting guard time and tear-free frame-synchronous value loading. It sits between the system wrapper's debug values (PC, data bus, opcode) and the board's cathode and anode pins.

## Interface
- `DIGITS`, 4: number of scanned digits (1..8).
- `CLK_HZ`, 100000000: frequency of `clk_in`.
- `REFRESH_HZ`, 1000: full-frame refresh rate. Per-digit period `DIV = max(1, CLK_HZ/(REFRESH_HZ*DIGITS))` cycles, integer-truncated.
- `GUARD`, 2: cycles at the start of each digit slot with all anodes off (0..DIV-1).
- `LZ_BLANK`, 1: enables leading-zero suppression.

Ports:
- `clk_in` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: scan enable.
- `load` in 1: single-cycle strobe that captures `value`, `dp_mask` and `blank_mask`.
- `value` in 4*DIGITS: hex nibbles. Nibble i drives digit i; digit 0 is rightmost.
- `dp_mask` in DIGITS: 1 lights the decimal point of digit i.
- `blank_mask` in DIGITS: 1 forces digit i dark.
- `c_out` out 8: cathodes {a,b,c,d,e,f,g,dp}, bit 7 = a, active-low.
- `a_out` out DIGITS: anodes, active-low, bit i = digit i.
- `frame_done` out 1: one-cycle pulse when a frame completes.

## Operation
- Reset (asynchronous, `reset`=0):
  - Divider count 0, digit index 0.
  - Shadow value, dp and blank registers 0; pending flag 0.
  - `a_out` all 1, `c_out` 8'hFF, `frame_done` 0.
- Divider: counts 0..DIV-1 while `enable`=1. A tick occurs on the cycle the count equals DIV-1; the count then wraps to 0.
- On a tick the index advances by 1. It wraps from DIGITS-1 to 0, and that wrap tick pulses `frame_done`.
- Load path:
  - `load`=1 captures the inputs into pending registers and sets the pending flag. A repeated load before transfer overwrites them; the latest load wins.
  - On each wrap tick with pending set, pending is copied to shadow and the flag clears.
  - If `load` coincides with the wrap tick, the incoming inputs go straight into shadow and pending stays clear.
  - The displayed frame never mixes old and new values.
- Decode, active-low hex with dp bit = 1 (off):
  - 0 → 8'h03, 1 → 8'h9F, 2 → 8'h25, 3 → 8'h0D, 4 → 8'h99, 5 → 8'h49, 6 → 8'h41, 7 → 8'h1F
  - 8 → 8'h01, 9 → 8'h19, A → 8'h11, b → 8'hC1, C → 8'h63, d → 8'h85, E → 8'h61, F → 8'h71
  - A set dp clears bit 0.
- Leading-zero suppression (`LZ_BLANK`=1): scanning from digit DIGITS-1 downward, zero nibbles are dark until the first nonzero nibble or the first digit with dp set. Digit 0 is never zero-suppressed.
- A dark digit (blanked or suppressed) drives `c_out`=8'hFF. Its anode is still asserted outside the guard window.
- `enable`=0:
  - Divider and index freeze.
  - `a_out` all 1, `c_out` 8'hFF.
  - Loads are still captured into pending.
  - On re-enable, scanning resumes from the held count and index.

## Timing
- `c_out` and `a_out` are registered. They reflect the current index and count one cycle after the edge that changed them.
- Slot timing:
  - `a_out` is all 1 for count 0..GUARD-1.
  - For count GUARD..DIV-1, `a_out` = ~(1<<index).
  - `c_out` updates at slot start, while the anodes are off.
- `frame_done` is high for exactly one cycle, registered, aligned with the first cycle of digit 0's slot.
- Load-to-display latency: up to one full frame (DIGITS*DIV cycles) plus 1 cycle.
- DIGITS=1: every tick is a wrap tick; `frame_done` pulses every DIV cycles.
- Reset mid-slot: outputs go dark immediately (asynchronous); pending data is discarded.

## Test plan
Bench parameters: CLK_HZ=4000, REFRESH_HZ=100, DIGITS=4 (DIV=10), GUARD=2.

- **Reset scan:** release reset, `enable`=1, load 16'h1234.
  - `a_out` cycles 1110→1101→1011→0111, each low for 8 of every 10 cycles.
  - `c_out` shows 8'h99, 8'h0D, 8'h25, 8'h9F.
  - `frame_done` pulses every 40 cycles.
- **Leading-zero suppression:** load 16'h0050.
  - Digits 3 and 2 drive 8'hFF.
  - Digit 1 shows 8'h49; digit 0 shows 8'h03.
  - Repeat with `dp_mask`=4'b0100: digit 2 shows 8'h02.
- **Tear-free load:** load 16'hAAAA mid-frame, then 16'hFFFF two cycles later.
  - The rest of that frame still shows the old value.
  - The next frame shows 8'h71 on all digits; 16'hAAAA is never displayed.
- **Load on wrap tick:** assert `load` on the wrap-tick cycle.
  - The new value appears in digit 0's slot immediately after.
- **Enable low mid-slot:** drop `enable` during digit 2's slot.
  - `a_out`=4'hF and `c_out`=8'hFF within 1 cycle.
  - On re-enable, digit 2 finishes its remaining count.
- **Asynchronous reset:** assert `reset`=0 between clock edges.
  - `a_out`=4'hF and `c_out`=8'hFF without waiting for a clock edge.
  - After release, digit 3 shows 8'hFF and digit 0 shows 8'h03 (shadow = 0).
